// File: rtl/dbus_responder.sv
// ----------------------------------------------------------------------------
// dbus_responder : fixed-latency, byte-strobed 64-bit data memory responder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dbus_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] count;
  logic [63:0]   addr_q, data_q;
  logic [2:0]    size_q;
  logic [7:0]    strobe_q;

  logic [63:0]   mem [DEPTH];

  logic [63:0]   sel_addr;
  logic [2:0]    sel_size;
  logic [7:0]    sel_strobe;
  logic [63:0]   word_idx;
  logic [AW-1:0] idx;
  logic          misaligned;
  logic          err;

  // In IDLE the live request is decoded so LATENCY=1 can respond on the next edge.
  assign sel_addr   = (state == IDLE) ? req_addr   : addr_q;
  assign sel_size   = (state == IDLE) ? req_size   : size_q;
  assign sel_strobe = (state == IDLE) ? req_strobe : strobe_q;

  assign word_idx = (sel_addr - BASE_ADDR) >> 3;
  assign idx      = word_idx[AW-1:0];

  always_comb begin
    misaligned = 1'b0;
    case (sel_size)
      3'd1:    misaligned = sel_addr[0];
      3'd2:    misaligned = |sel_addr[1:0];
      3'd3:    misaligned = |sel_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign err = misaligned || (word_idx >= 64'(DEPTH)) || (sel_size > 3'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (count == CW'(1)) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      data_q       <= '0;
      resp_addr_ok <= 1'b0;
      resp_data_ok <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
    end else begin
      resp_addr_ok <= 1'b0;
      resp_data_ok <= 1'b0;
      if (state == IDLE && req_valid) begin
        addr_q   <= req_addr;
        size_q   <= req_size;
        strobe_q <= req_strobe;
        data_q   <= req_data;
        count    <= LOAD;
      end else if (state == WAIT) begin
        count <= count - CW'(1);
      end
      if (next_state == RESP && state != RESP) begin
        resp_addr_ok <= 1'b1;
        resp_data_ok <= 1'b1;
        resp_err     <= err;
        resp_data    <= (err || sel_strobe != 8'h00) ? 64'h0 : mem[idx];
      end
    end
  end

  // Array is deliberately outside reset; a reset in RESP leaves state=IDLE so nothing commits.
  always_ff @(posedge clk) begin
    if (state == RESP && !err) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbus_responder.sv
// ----------------------------------------------------------------------------
// tb_dbus_responder : directed-vector bench over LATENCY = 2, 4 and 1 instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        v     [3];
  logic [63:0] a     [3];
  logic [2:0]  sz    [3];
  logic [7:0]  st    [3];
  logic [63:0] d     [3];
  logic        aok   [3];
  logic        dok   [3];
  logic [63:0] rdata [3];
  logic        rerr  [3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dbus_responder #(.LATENCY(2)) u0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(v[0]), .req_addr(a[0]), .req_size(sz[0]),
    .req_strobe(st[0]), .req_data(d[0]), .resp_addr_ok(aok[0]), .resp_data_ok(dok[0]),
    .resp_data(rdata[0]), .resp_err(rerr[0]));

  dbus_responder #(.LATENCY(4)) u1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(v[1]), .req_addr(a[1]), .req_size(sz[1]),
    .req_strobe(st[1]), .req_data(d[1]), .resp_addr_ok(aok[1]), .resp_data_ok(dok[1]),
    .resp_data(rdata[1]), .resp_err(rerr[1]));

  dbus_responder #(.LATENCY(1)) u2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(v[2]), .req_addr(a[2]), .req_size(sz[2]),
    .req_strobe(st[2]), .req_data(d[2]), .resp_addr_ok(aok[2]), .resp_data_ok(dok[2]),
    .resp_data(rdata[2]), .resp_err(rerr[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request from an IDLE cycle; returns in the IDLE cycle after the response.
  task automatic access(input int u, input logic [63:0] addr, input logic [2:0] size,
                        input logic [7:0] strobe, input logic [63:0] data, input int exp_lat,
                        input logic exp_err, input logic [63:0] exp_data, input bit scramble,
                        input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    v[u] = 1'b1; a[u] = addr; sz[u] = size; st[u] = strobe; d[u] = data;
    @(posedge clk); #1;
    v[u] = 1'b0;
    if (scramble) begin
      a[u] = addr ^ 64'h8; st[u] = 8'hFF; d[u] = '1;
    end
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (dok[u]) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, "/lat"},  64'(lat), 64'(exp_lat));
    check({tag, "/aok"},  {63'b0, aok[u]}, {63'b0, dok[u]});
    check({tag, "/err"},  {63'b0, rerr[u]}, {63'b0, exp_err});
    check({tag, "/data"}, rdata[u], exp_data);
    @(posedge clk); #1;
  endtask

  task automatic watch_quiet(input int u, input int n, input string tag);
    logic any;
    any = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      any = any | aok[u] | dok[u];
    end
    check(tag, {63'b0, any}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pulses;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; v[i] = 1'b0; a[i] = '0; sz[i] = '0; st[i] = '0; d[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d/flags", i), {61'b0, aok[i], dok[i], rerr[i]}, 64'h0);
      check($sformatf("rst%0d/data", i), rdata[i], 64'h0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    watch_quiet(0, 5, "idle_quiet");

    // LATENCY = 2
    access(0, 64'h8000_0000, 3'd3, 8'hFF, 64'hDEAD_BEEF_0000_0001, 2, 1'b0, 64'h0, 1'b0, "w0");
    access(0, 64'h8000_0010, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 2, 1'b0, 64'h0, 1'b0, "wfull");
    access(0, 64'h8000_0010, 3'd3, 8'h00, 64'h0, 2, 1'b0, 64'h1122_3344_5566_7788, 1'b0, "rfull");
    access(0, 64'h8000_0012, 3'd1, 8'h0C, 64'h0000_0000_ABCD_0000, 2, 1'b0, 64'h0, 1'b0, "wpart");
    access(0, 64'h8000_0010, 3'd3, 8'h00, 64'h0, 2, 1'b0, 64'h1122_3344_ABCD_7788, 1'b0, "rpart");
    access(0, 64'h8000_0013, 3'd2, 8'h00, 64'h0, 2, 1'b1, 64'h0, 1'b0, "mis4");
    access(0, 64'h8000_0011, 3'd1, 8'h00, 64'h0, 2, 1'b1, 64'h0, 1'b0, "mis2");
    access(0, 64'h8000_0013, 3'd0, 8'h00, 64'h0, 2, 1'b0, 64'h1122_3344_ABCD_7788, 1'b0, "byte_odd");
    access(0, 64'h8000_0800, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 64'h0, 1'b0, "w_oor");
    access(0, 64'h8000_0000, 3'd3, 8'h00, 64'h0, 2, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0, "r_alias");
    access(0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'h0, 2, 1'b1, 64'h0, 1'b0, "r_below");
    access(0, 64'h8000_0010, 3'd4, 8'h00, 64'h0, 2, 1'b1, 64'h0, 1'b0, "badsize");
    access(0, 64'h8000_07F8, 3'd3, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 2, 1'b0, 64'h0, 1'b0, "w_last");
    access(0, 64'h8000_07F8, 3'd3, 8'h00, 64'h0, 2, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 1'b0, "r_last");

    // LATENCY = 4
    access(1, 64'h8000_0000, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 4, 1'b0, 64'h0, 1'b0, "l4_wA");
    access(1, 64'h8000_0008, 3'd3, 8'hFF, 64'h5A5A_A5A5_0F0F_F0F0, 4, 1'b0, 64'h0, 1'b0, "l4_wZ");
    access(1, 64'h8000_0000, 3'd3, 8'h00, 64'h0, 4, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, "l4_scr");
    access(1, 64'h8000_0008, 3'd3, 8'h00, 64'h0, 4, 1'b0, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0, "l4_rZ");

    // reset during WAIT drops the write
    @(negedge clk);
    v[1] = 1'b1; a[1] = 64'h8000_0000; sz[1] = 3'd3; st[1] = 8'hFF; d[1] = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    v[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    watch_quiet(1, 6, "l4_rstwait_quiet");
    access(1, 64'h8000_0000, 3'd3, 8'h00, 64'h0, 4, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, "l4_after_wait_rst");

    // reset during RESP clears outputs at once and blocks the commit
    @(negedge clk);
    v[1] = 1'b1; a[1] = 64'h8000_0000; sz[1] = 3'd3; st[1] = 8'hFF; d[1] = 64'hC0C0_C0C0_C0C0_C0C0;
    @(posedge clk); #1;
    v[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("l4_resp_pulse", {63'b0, dok[1]}, 64'h1);
    rst_n[1] = 1'b0;
    #1;
    check("l4_resp_async_clear", {62'b0, aok[1], dok[1]}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    access(1, 64'h8000_0000, 3'd3, 8'h00, 64'h0, 4, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, "l4_after_resp_rst");

    // LATENCY = 1, back-to-back
    access(2, 64'h8000_0000, 3'd3, 8'hFF, 64'hAAAA_0000_1111_2222, 1, 1'b0, 64'h0, 1'b0, "l1_wX");
    access(2, 64'h8000_0008, 3'd3, 8'hFF, 64'h3333_4444_BBBB_5555, 1, 1'b0, 64'h0, 1'b0, "l1_wY");
    @(negedge clk);
    v[2] = 1'b1; a[2] = 64'h8000_0000; sz[2] = 3'd3; st[2] = 8'h00; d[2] = '0;
    pulses = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      pulses[k-1] = dok[2];
      if (k == 1) check("l1_b2b_c1", rdata[2], 64'hAAAA_0000_1111_2222);
      if (k == 3) check("l1_b2b_c3", rdata[2], 64'h3333_4444_BBBB_5555);
      if (k == 5) check("l1_b2b_c5", rdata[2], 64'h3333_4444_BBBB_5555);
      if (k == 1) a[2] = 64'h8000_0008;
      if (k == 5) v[2] = 1'b0;
    end
    check("l1_b2b_pulses", {58'b0, pulses}, 64'h15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbus_responder.md
# dbus_responder

Data-bus responder that serves load/store requests issued by the pipeline's memory stage. It sits on the far side of the core's data-bus interface and fronts a word-addressed, byte-strobed 64-bit memory array with a fixed, parameterized access latency. It is used as the simulation and FPGA data memory, and as the reference responder when verifying the memory stage's request/stall logic.

## Interface
Parameters:
- DEPTH, 256: number of 64-bit words in the array.
- LATENCY, 2: cycles from request acceptance to response. Must be ≥1.
- BASE_ADDR, 64'h8000_0000: byte address of word 0. Must be 8-byte aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_addr  in  64  byte address.
- req_size  in  3  access size code: 0=1B, 1=2B, 2=4B, 3=8B. Other codes are illegal.
- req_strobe  in  8  byte-lane write enables. All zeros means a read.
- req_data  in  64  write data, lane-aligned to the word.
- resp_addr_ok  out  1  request consumed. One-cycle pulse.
- resp_data_ok  out  1  response valid. One-cycle pulse, coincident with resp_addr_ok.
- resp_data  out  64  read data (full aligned word).
- resp_err  out  1  the access was misaligned, out of range, or used an illegal size code. Valid with resp_data_ok.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - On req_valid=1, latch addr/size/strobe/data.
  - Load the counter with LATENCY-1.
  - Go to WAIT if LATENCY>1, otherwise go to RESP.
- **WAIT:**
  - Decrement the counter each cycle.
  - Go to RESP when the counter reaches 1.
  - req_* changes are ignored because the latched copy is used.
  - Dropping req_valid does not abort the access.
- **RESP:**
  - resp_addr_ok=resp_data_ok=1 for exactly one cycle, then go to IDLE.
  - Minimum one IDLE cycle between responses.
- Index = (addr − BASE_ADDR) >> 3, using 64-bit unsigned subtraction.
  - An address below BASE_ADDR wraps to a huge index and is therefore out of range.
- **Error rules:**
  - Misaligned: addr[size-1:0] ≠ 0 for size 1..3. Size 0 is never misaligned.
  - Out of range: index ≥ DEPTH.
  - Illegal size: req_size > 3.
  - Any error: no array write, resp_data=0, resp_err=1.
- **Read (strobe=0, no error):** resp_data = array[index], i.e. the whole word regardless of size. The initiator extracts and extends the bytes.
- **Write (strobe≠0, no error):**
  - For each lane i with strobe[i]=1, array[index] byte i ← req_data byte i.
  - resp_data=0 on writes.
  - Strobe/size consistency is not checked.
- The array is not reset; its contents are preserved across reset. Initial contents are zero in simulation.

## Timing
- Cycle 0 is the first cycle req_valid=1 is sampled high in IDLE. The response is visible in cycle LATENCY. Throughput is one access per LATENCY+1 cycles.
- All outputs are registered.
- Read data is captured on the edge entering RESP. The write commits on the edge leaving RESP.
  - A read accepted after a write's response therefore sees the new data.
- Reset values: state=IDLE, counter=0, resp_addr_ok=0, resp_data_ok=0, resp_data=0, resp_err=0.
- Reset asserted in WAIT or RESP:
  - Outputs clear immediately (asynchronously).
  - The pending access is dropped, and a write in RESP is not committed.
  - After release, IDLE accepts a fresh request on the first rising edge.
- req_valid held high through the RESP cycle is not re-accepted in that cycle. If still high in the following IDLE cycle, it is treated as a new request.

## Test plan
- **Reset check:** hold reset=0 for 3 cycles → all outputs 0, state IDLE; release, req_valid=0 for 5 cycles → no pulses.
- **Full-word write then read (LATENCY=2):**
  - Write addr=0x8000_0010, size=3, strobe=0xFF, data=0x1122_3344_5566_7788 → ok pulse in cycle 2, err=0.
  - Read the same addr → resp_data=0x1122_3344_5566_7788 in cycle 2.
- **Partial write:** after the above, write addr=0x8000_0012, size=1, strobe=0x0C, data=0x0000_0000_ABCD_0000 → subsequent read returns 0x1122_3344_ABCD_7788.
- **Error cases:**
  - Read at 0x8000_0013 with size=2 → resp_err=1, resp_data=0.
  - Write at BASE_ADDR+8·DEPTH → err=1, array unchanged.
  - Read at 0x7FFF_FFF8 → err=1.
- **Reset mid-WAIT (LATENCY=4):** write at 0x8000_0000, assert reset in cycle 2 → no response; subsequent read returns the prior value.
- **Back-to-back (LATENCY=1):** hold req_valid=1 for 6 cycles with reads → ok pulses in cycles 1, 3, 5. Stable req_* during WAIT is ignored, and a changed req_addr mid-WAIT has no effect on the result.
